// File: rtl/ext_int_filter.sv
// Per-channel glitch filter, edge detector and sticky W1C interrupt-pending bits.
// One lane instance per channel; lanes share only the effective filter length.
module ext_int_filter_lane #(
  parameter int   CNT_W   = 16,
  parameter logic RST_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [CNT_W-1:0] n_m1,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             clr,
  output logic             filt_out,
  output logic             pending
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic             diff, commit, rise, fall;

  assign diff   = din ^ filt_out;
  // >= rather than == so that lowering the length mid-count commits at once
  assign commit = diff && (cnt >= n_m1);
  assign rise   = commit &  din;
  assign fall   = commit & ~din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      filt_out <= RST_BIT;
      pending  <= 1'b0;
    end else begin
      if (!diff || commit)  cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + CNT_ONE;
      if (commit) filt_out <= din;
      // a same-cycle event beats the clear so no edge is ever dropped
      pending <= (pending & ~clr) | (rise & rise_en) | (fall & fall_en);
    end
  end
endmodule

module ext_int_filter #(
  parameter int              DW      = 8,
  parameter int              CNT_W   = 16,
  parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    din,
  input  logic [CNT_W-1:0] filt_cycles,
  input  logic [DW-1:0]    rise_en,
  input  logic [DW-1:0]    fall_en,
  input  logic             clr_we,
  input  logic [DW-1:0]    clr_data,
  output logic [DW-1:0]    filt_out,
  output logic [DW-1:0]    pending,
  output logic             irq
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] n_m1;
  logic [DW-1:0]    clr;

  // a length of 0 behaves as 1, so the commit threshold N-1 is 0 in both cases
  assign n_m1 = (filt_cycles == '0) ? '0 : filt_cycles - CNT_ONE;
  assign clr  = clr_data & {DW{clr_we}};
  assign irq  = |pending;

  for (genvar i = 0; i < DW; i++) begin : g_lane
    ext_int_filter_lane #(
      .CNT_W   (CNT_W),
      .RST_BIT (RST_VAL[i])
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .din      (din[i]),
      .n_m1     (n_m1),
      .rise_en  (rise_en[i]),
      .fall_en  (fall_en[i]),
      .clr      (clr[i]),
      .filt_out (filt_out[i]),
      .pending  (pending[i])
    );
  end
endmodule

// File: doc/ext_int_filter.md
Name: ext_int_filter

Overview:
- Per-channel glitch filter, edge detector and sticky interrupt-pending register for external interrupt and GPIO inputs.
- Sits directly downstream of the 2-stage input synchronizer. Consumes its already-synchronized `din` and produces clean levels plus an interrupt request toward the core's interrupt controller.
- Software programs the filter length and edge selection, and clears pending bits write-1-to-clear.

Parameters:
- DW, 8, number of independent input channels.
- CNT_W, 16, width of filter length and of each channel's stability counter.
- RST_VAL, {DW{1'b0}}, reset value of `filt_out`. Set this bit to 1 for active-low inputs so reset release creates no spurious edge.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- din  input  DW  synchronized raw inputs; no further synchronization is done here.
- filt_cycles  input  CNT_W  required stable cycles; a value of 0 is treated as 1.
- rise_en  input  DW  per-channel enable for setting pending on a rising filtered edge.
- fall_en  input  DW  per-channel enable for setting pending on a falling filtered edge.
- clr_we  input  1  pending-clear strobe, one cycle.
- clr_data  input  DW  write-1-to-clear mask, valid when `clr_we`=1.
- filt_out  output  DW  filtered level, registered.
- pending  output  DW  sticky pending bits, registered.
- irq  output  1  OR-reduction of `pending`; combinational from registers only.

Behaviour:
- Reset (rst=0, asynchronous):
  - `filt_out` = RST_VAL.
  - `pending` = 0, all counters = 0, so `irq` = 0.
- Effective length: N = (filt_cycles==0) ? 1 : filt_cycles.
- Per channel i, evaluated each rising clk edge with counter cnt[i]:
  - din[i]==filt_out[i]: cnt[i] <= 0; filt_out[i] holds.
  - din[i]!=filt_out[i] and cnt[i] >= N-1: commit. filt_out[i] <= din[i] and cnt[i] <= 0.
  - din[i]!=filt_out[i] and cnt[i] < N-1: cnt[i] <= cnt[i]+1. The counter saturates at all-ones and never wraps.
- Latency: a change that holds for N consecutive sampled cycles appears on `filt_out` after the Nth sampling edge. Any return to the old level before that restarts counting from 0.
- `filt_cycles` is sampled live. The `>=` compare means lowering it mid-count commits at the next edge. Raising it extends the wait; no channel state is lost.
- Edge event, same edge as the commit:
  - rise[i] = commit with din[i]=1.
  - fall[i] = commit with din[i]=0.
- Pending update per edge:
  - pending[i] <= (pending[i] & ~(clr_we & clr_data[i])) | (rise[i]&rise_en[i]) | (fall[i]&fall_en[i]).
  - A new event in the same cycle as a clear wins: the bit ends up set, so no event is lost.
- `irq` = |pending. It rises in the cycle after the committing edge, i.e. the same cycle `pending` becomes visible.
- Disabling `rise_en`/`fall_en` stops new sets only. Existing pending bits stay until cleared.
- Channels are fully independent. No clock gating and no multicycle paths.
- Mid-operation reset:
  - All counters and pending bits clear immediately.
  - `filt_out` returns to RST_VAL.
  - After release, an input already differing from RST_VAL is filtered normally and may generate one edge event.

Test Plan:
- Reset/values: DW=8, RST_VAL=8'h01, hold rst=0 with din=8'hFF → filt_out=8'h01, pending=0, irq=0. Release with filt_cycles=4, rise_en=8'hFF → after the 4th edge filt_out=8'hFF and pending=8'hFE, because bit0 had no edge.
- Glitch rejection: filt_cycles=5, din[3] pulses high for 4 cycles then low → filt_out[3] stays 0, pending=0, cnt returns to 0. A 5-cycle pulse → filt_out[3] goes high after the 5th edge, returns low 5 edges after the fall, and pending[3] is set if rise_en[3] or fall_en[3].
- Edge selection: rise_en=8'h00, fall_en=8'h04, filt_cycles=1, din[2] 0→1→0 held 3 cycles each → pending[2] stays 0 after the rise and sets one edge after the falling input. irq follows.
- Clear vs. set collision: pending=8'h10, and on the same edge clr_we=1, clr_data=8'h30 and channel 4 commits a rising edge with rise_en[4]=1 → pending=8'h10 and irq stays 1. The next clear with no event → pending=8'h00, irq=0.
- filt_cycles=0 and live change: filt_cycles=0 → behaves as N=1, one-edge latency. Set filt_cycles=100, change din[0], let cnt reach 50, then write filt_cycles=10 → commit on the next edge.
- Async reset mid-count: filt_cycles=20, din[7] changed for 10 cycles, pending=8'h81, then pulse rst low between clock edges → pending=0, irq=0 and filt_out=RST_VAL immediately without a clock. After release, din[7] needs a full 20 cycles to commit.
